// File: rtl/program_loader.sv
// program_loader: fills instruction memory from a length-prefixed little-endian byte stream.
//
// Optional feature: define LOADER_VERIFY_EN to read back every written word
// through debug_data_out and abort the session on a mismatch.
//
// Parameters:
//   BASE_ADDR       byte address of the first program word (word-aligned)
//   MAX_WORDS       largest accepted program length in words
// Ports:
//   clk             clock, all state updates on the rising edge
//   reset_n         synchronous active-low reset
//   start           begins a load session, sampled in IDLE only
//   byte_valid      stream byte available
//   byte_data       stream byte
//   byte_ready      loader accepts a byte this cycle (LEN and DATA only)
//   debug_en        memory debug enable
//   debug_write_en  memory debug write enable
//   debug_addr      memory debug byte address
//   debug_data_in   memory write data
//   debug_data_out  combinational memory readback
//   cpu_hold        core held in reset while the session is active
//   busy            high in every state except IDLE
//   done            one-cycle pulse on successful completion
//   error           sticky failure flag, cleared by the next accepted start
//   words_loaded    words written this session
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MAX_WORDS = 32'd1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        debug_en,
    output logic        debug_write_en,
    output logic [31:0] debug_addr,
    output logic [31:0] debug_data_in,
    input  logic [31:0] debug_data_out,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] words_loaded
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, VERIFY, ADVANCE, DONE, ERROR} state_t;

    state_t      state, state_nx;
    logic [31:0] len, word, wl;
    logic [1:0]  bidx;
    logic        err;
    logic        accept, last_byte;
    logic [31:0] len_full;

    assign accept    = byte_valid && byte_ready;
    assign last_byte = accept && bidx == 2'd3;
    // Header value as it will look once the byte being accepted is shifted in.
    assign len_full  = {byte_data, len[31:8]};

`ifndef LOADER_VERIFY_EN
    logic unused_readback;
    assign unused_readback = ^debug_data_out;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Bytes shift in from the top so the first byte of a group ends in [7:0].
    // The word index doubles as words_loaded since both advance together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len  <= '0;
            word <= '0;
            wl   <= '0;
            bidx <= '0;
            err  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                wl   <= '0;
                bidx <= '0;
                err  <= 1'b0;
            end
            if (accept) begin
                bidx <= bidx + 2'd1;
                if (state == LEN)
                    len <= len_full;
                else
                    word <= {byte_data, word[31:8]};
            end
            if (state == ADVANCE)
                wl <= wl + 32'd1;
            if (state_nx == ERROR)
                err <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LEN : IDLE;
            LEN:     state_nx = !last_byte ? LEN :
                                len_full == '0 ? DONE :
                                len_full > MAX_WORDS ? ERROR : DATA;
            DATA:    state_nx = last_byte ? WRITE : DATA;
`ifdef LOADER_VERIFY_EN
            WRITE:   state_nx = VERIFY;
            VERIFY:  state_nx = debug_data_out != word ? ERROR : ADVANCE;
`else
            WRITE:   state_nx = ADVANCE;
`endif
            ADVANCE: state_nx = wl + 32'd1 == len ? DONE : DATA;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        byte_ready     = state == LEN || state == DATA;
        debug_en       = state == WRITE || state == VERIFY;
        debug_write_en = state == WRITE;
        debug_addr     = debug_en ? BASE_ADDR + {wl[29:0], 2'b00} : '0;
        debug_data_in  = debug_en ? word : '0;
        cpu_hold       = state == LEN || state == DATA || state == WRITE ||
                         state == VERIFY || state == ADVANCE;
        busy           = state != IDLE;
        done           = state == DONE;
        error          = err;
        words_loaded   = wl;
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven sessions with a write scoreboard for program_loader.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, debug_en, debug_write_en, cpu_hold, busy, done, error;
    logic [31:0] debug_addr, debug_data_in, debug_data_out, words_loaded;

    program_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .debug_en(debug_en),
        .debug_write_en(debug_write_en), .debug_addr(debug_addr),
        .debug_data_in(debug_data_in), .debug_data_out(debug_data_out),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

`ifdef LOADER_VERIFY_EN
    localparam int WLAT = 3;
`else
    localparam int WLAT = 2;
`endif

    logic [31:0] mem [1024];
    bit          corrupt_w1 = 1'b0;
    assign debug_data_out = (corrupt_w1 && debug_addr == 32'h4) ? 32'hDEADBEEF : mem[debug_addr[11:2]];
    always @(posedge clk) if (debug_en && debug_write_en) mem[debug_addr[11:2]] <= debug_data_in;

    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    int          done_cnt = 0;
    int          bad_we = 0;
    always @(negedge clk) begin
        if (debug_write_en) obs_q.push_back({debug_addr, debug_data_in});
        if (debug_write_en && !debug_en) bad_we++;
        if (done) done_cnt++;
    end

    typedef struct {
        logic [31:0] len;
        logic [31:0] w0, w1, w2;
        bit          gap;
        bit          exp_err;
        logic [31:0] exp_wl;
    } vec_t;
    vec_t vt[6];

    int applied = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) chk("byte_ready_timeout", {31'b0, byte_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
        byte_valid = 1'b0;
    endtask

    task automatic drain_writes(input string tag);
        logic [63:0] o, e;
        chk({tag, "_write_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_write_addr"}, o[63:32], e[63:32]);
            chk({tag, "_write_data"}, o[31:0], e[31:0]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic begin_session(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_hold_start"}, cpu_hold, 1);
        chk({tag, "_error_cleared"}, error, 0);
        chk({tag, "_wl_cleared"}, words_loaded, 0);
    endtask

    task automatic wait_end(output int lat);
        lat = 0;
        while (!(done || error) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("end_seen", {31'b0, done || error}, 1);
    endtask

    task automatic run_session(input vec_t v, input string tag);
        int          base, lat, nw;
        logic [31:0] w;
        base = done_cnt;
        begin_session(tag);
        send_word(v.len, 1'b0);
        if (v.len == 0) chk({tag, "_done_next"}, done, 1);
        nw = v.exp_err ? 0 : int'(v.len);
        for (int j = 0; j < nw; j++) begin
            w = j == 0 ? v.w0 : j == 1 ? v.w1 : v.w2;
            exp_q.push_back({32'(4 * j), w});
            for (int i = 0; i < 4; i++) begin
                if (v.gap && j == 1 && i == 2) begin
                    byte_valid = 1'b0;
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    chk({tag, "_busy_mid"}, busy, 1);
                    chk({tag, "_hold_mid"}, cpu_hold, 1);
                end
                send_byte(w[8*i +: 8], v.gap);
            end
            byte_valid = 1'b0;
        end
        wait_end(lat);
        if (nw > 0) chk({tag, "_latency"}, lat, WLAT);
        chk({tag, "_done"}, done, {31'b0, !v.exp_err});
        chk({tag, "_error"}, error, {31'b0, v.exp_err});
        @(negedge clk);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_hold_end"}, cpu_hold, 0);
        chk({tag, "_wl"}, words_loaded, v.exp_wl);
        chk({tag, "_error_sticky"}, error, {31'b0, v.exp_err});
        chk({tag, "_done_pulses"}, done_cnt - base, v.exp_err ? 0 : 1);
        byte_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_idle"}, byte_ready, 0);
        byte_valid = 1'b0;
        drain_writes(tag);
    endtask

    initial begin
        int lat;
        vt[0] = '{32'd2, 32'h00500093, 32'h00000013, 32'h0, 1'b0, 1'b0, 32'd2};
        vt[1] = '{32'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0};
        vt[2] = '{32'd3, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 1'b1, 1'b0, 32'd3};
        vt[3] = '{32'd1025, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0};
        vt[4] = '{32'd1, 32'hA5A55A5A, 32'h0, 32'h0, 1'b0, 1'b0, 32'd1};
        vt[5] = '{32'h00010000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_ready", byte_ready, 0);
        chk("rst_error", error, 0);
        chk("rst_wl", words_loaded, 0);
        chk("rst_debug_en", debug_en, 0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vt[k]) run_session(vt[k], $sformatf("vec%0d", k));

`ifdef LOADER_VERIFY_EN
        corrupt_w1 = 1'b1;
        begin_session("verify");
        send_word(32'd3, 1'b0);
        exp_q.push_back({32'h0, 32'h11111111});
        exp_q.push_back({32'h4, 32'h22222222});
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        wait_end(lat);
        chk("verify_latency", lat, 2);
        chk("verify_error", error, 1);
        chk("verify_done", done, 0);
        chk("verify_wl", words_loaded, 1);
        @(negedge clk);
        chk("verify_hold_end", cpu_hold, 0);
        chk("verify_busy_end", busy, 0);
        repeat (3) @(negedge clk);
        drain_writes("verify");
        corrupt_w1 = 1'b0;
`endif

        begin_session("rstmid");
        send_word(32'd2, 1'b0);
        send_byte(8'h93, 1'b0);
        byte_data = 8'h00;
        reset_n = 1'b0;
        @(negedge clk);
        byte_valid = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_hold", cpu_hold, 0);
        chk("rstmid_ready", byte_ready, 0);
        chk("rstmid_debug_en", debug_en, 0);
        chk("rstmid_debug_we", debug_write_en, 0);
        chk("rstmid_debug_addr", debug_addr, 0);
        chk("rstmid_debug_data", debug_data_in, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_error", error, 0);
        chk("rstmid_wl", words_loaded, 0);
        reset_n = 1'b1;
        @(negedge clk);
        drain_writes("rstmid");
        run_session(vt[0], "after_rst");

        chk("we_without_en", bad_we, 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Debug-port initiator that fills instruction memory from a byte stream before the core runs. It accepts a length-prefixed, little-endian byte stream (e.g. from a UART receiver) and assembles 32-bit words. Each word is written through instruction memory's debug interface at consecutive word addresses. The core is held off via `cpu_hold` for the whole session.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of the first program word; must be word-aligned.
- `MAX_WORDS`, 1024: largest accepted program length in words; matches instruction memory depth.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begins a load session; sampled in IDLE only.
- `byte_valid`  in  1  stream byte available.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts byte this cycle.
- `debug_en`  out  1  to memory debug enable.
- `debug_write_en`  out  1  to memory debug write enable.
- `debug_addr`  out  32  to memory debug address (byte address, word-aligned).
- `debug_data_in`  out  32  write data to memory.
- `debug_data_out`  in  32  combinational readback from memory.
- `cpu_hold`  out  1  high while session is active; core held in reset.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky failure flag; cleared by next accepted `start`.
- `words_loaded`  out  32  count of words written this session.

## Operation
- Byte handshake: transfer occurs on a rising edge with `byte_valid && byte_ready`. `byte_ready` is high only in LEN and DATA.
- Byte order: the first byte of each 4-byte group lands in bits [7:0], the fourth in [31:24].
- FSM states:
  - IDLE: on `start`, clear `error`, `words_loaded`, the byte index and the word index; go to LEN.
  - LEN: collect 4 header bytes into `len`. After the 4th byte: `len == 0` goes to DONE; `len > MAX_WORDS` goes to ERROR; otherwise go to DATA.
  - DATA: collect 4 bytes into the word register, then go to WRITE.
  - WRITE: `debug_en = debug_write_en = 1`; `debug_addr = BASE_ADDR + 4*idx`, mod 2^32; `debug_data_in = word`. Next state is VERIFY if `LOADER_VERIFY_EN` is defined, otherwise ADVANCE.
  - VERIFY: `debug_en = 1`, `debug_write_en = 0`, same address. If `debug_data_out != word`, go to ERROR; otherwise ADVANCE.
  - ADVANCE: `idx++`, `words_loaded++`. Go to DONE if `idx+1 == len`, else DATA.
  - DONE: assert `done` for one cycle, drop `cpu_hold`, go to IDLE.
  - ERROR: set `error`, drop `cpu_hold`, go to IDLE. `error` holds until the next accepted `start`.
- `start` outside IDLE is ignored. Stream bytes arriving outside LEN/DATA are not consumed.
- `debug_write_en` is never high without `debug_en`. Debug outputs are 0 in all states except WRITE and VERIFY.
- `cpu_hold` is high from the cycle after `start` is accepted until the DONE/ERROR state is entered.

## Timing
- Reset (`reset_n` low at an edge) forces state IDLE. All outputs are 0, including `cpu_hold`, `error` and `words_loaded`. Reset mid-session abandons the session; partially loaded memory is not restored.
- Per word without verify: 4 accept cycles + WRITE + ADVANCE. With verify, add 1 cycle (VERIFY).
- Memory captures the write at the rising edge that ends the WRITE cycle. VERIFY reads in the following cycle.
- `done` rises in the cycle after the final ADVANCE. For `len == 0`, it rises in the cycle after the 4th header byte.
- Back-to-back bytes with `byte_valid` held high are accepted one per cycle in LEN/DATA. Gaps simply stall the FSM.

## Configuration
- `LOADER_VERIFY_EN` defined: the VERIFY state is present; a readback mismatch ends the session in ERROR, and `words_loaded` excludes the failing word.
- Macro absent: the VERIFY state and comparator are removed. WRITE goes directly to ADVANCE, and `debug_data_out` is unused.

## Test plan
- Normal load: start, header `02 00 00 00`, bytes `93 00 50 00 13 00 00 00`. Required: write 0x00500093 @0x0 and 0x00000013 @0x4; `done` pulses once; `words_loaded = 2`; `error = 0`; `cpu_hold` low after done.
- Zero length: header `00 00 00 00`. Required: no `debug_write_en` pulses; `done` the next cycle; `words_loaded = 0`.
- Oversize: header `01 04 00 00` (1025). Required: ERROR; `error = 1`; zero writes; `byte_ready = 0` afterwards; a new `start` clears `error`.
- Stall/ignore: `byte_valid` toggled every other cycle, and `start` pulsed mid-DATA. Required: correct words; the extra `start` has no effect; `busy` stays high.
- Verify (`LOADER_VERIFY_EN`): model forces `debug_data_out = 0xDEADBEEF` on word 1 of 3. Required: ERROR after the VERIFY cycle; `words_loaded = 1`; no further writes.
- Reset mid-load: `reset_n` low during the 2nd DATA byte. Required: all outputs 0 the next cycle; a fresh session after release loads correctly from `BASE_ADDR`.
